// File: rtl/sram_1w_nr_sync_if.sv
// Bus bundle for the 1-write / N-read synchronous SRAM: clear control, write port, read ports.
interface sram_1w_nr_sync_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned NUM_RD = 2
);
    logic                       clr_start;
    logic                       busy;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_valid;
    logic [NUM_RD-1:0]          rd_err;

    modport master (
        output clr_start, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid, rd_err
    );

    modport slave (
        input  clr_start, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid, rd_err
    );
endinterface

// File: rtl/sram_1w_nr_sync.sv
// Synchronous SRAM model: one write port, NUM_RD pipelined read ports with valid/err tags,
// and a clear sequencer that zeroes one word per cycle.
module sram_1w_nr_sync #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned NUM_RD      = 2,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WRITE_FIRST = 0
) (
    input  logic               clock,
    input  logic               reset,
    sram_1w_nr_sync_if.slave   bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} stateE;

    stateE               state;
    stateE               stateNext;
    logic                idle;
    logic                clearing;
    logic [IDX_W-1:0]    clrCnt;
    logic                busyQ;
    logic                wrInRange;
    logic                wrAccept;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [NUM_RD-1:0]        rdValid;
    logic [NUM_RD-1:0]        rdErr;
    logic [NUM_RD*DATA_W-1:0] rdData;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.clr_start) stateNext = CLEAR;
            CLEAR:   if (clrCnt == IDX_W'(DEPTH - 1)) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        idle     = 1'b0;
        clearing = 1'b0;
        case (state)
            IDLE:    idle     = 1'b1;
            CLEAR:   clearing = 1'b1;
            default: idle     = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clrCnt <= '0;
            busyQ  <= 1'b0;
        end else begin
            clrCnt <= idle ? '0 : clrCnt + IDX_W'(1);
            busyQ  <= (stateNext == CLEAR);
        end
    end

    assign wrInRange = ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign wrAccept  = idle && bus.wr_en && wrInRange;

    // Array is never reset; a reset edge also suppresses any write or clear step
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clearing) begin
                mem[clrCnt] <= '0;
            end else if (wrAccept) begin
                mem[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : gRd
        logic [ADDR_W-1:0] addr;
        logic              inRange;
        logic              req;
        logic [DATA_W-1:0] rawData;
        logic [RD_LAT-1:0] pValid;
        logic [RD_LAT-1:0] pErr;
        logic [DATA_W-1:0] pData [RD_LAT];

        assign addr    = bus.rd_addr[p*ADDR_W +: ADDR_W];
        assign inRange = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
        assign req     = idle && bus.rd_en[p];

        always_comb begin
            rawData = '0;
            if (inRange) begin
                rawData = mem[addr[IDX_W-1:0]];
                if ((WRITE_FIRST != 0) && wrAccept && (bus.wr_addr == addr)) begin
                    rawData = bus.wr_data;
                end
            end
        end

        // Data only advances with a valid token so the output holds between reads
        always_ff @(posedge clock) begin
            if (reset) begin
                pValid <= '0;
                pErr   <= '0;
                for (int k = 0; k < RD_LAT; k++) begin
                    pData[k] <= '0;
                end
            end else begin
                pValid[0] <= req;
                pErr[0]   <= req && !inRange;
                if (req) begin
                    pData[0] <= rawData;
                end
                for (int k = 1; k < RD_LAT; k++) begin
                    pValid[k] <= pValid[k-1];
                    pErr[k]   <= pErr[k-1];
                    if (pValid[k-1]) begin
                        pData[k] <= pData[k-1];
                    end
                end
            end
        end

        assign rdValid[p]                 = pValid[RD_LAT-1];
        assign rdErr[p]                   = pErr[RD_LAT-1];
        assign rdData[p*DATA_W +: DATA_W] = pData[RD_LAT-1];
    end

    assign bus.busy     = busyQ;
    assign bus.rd_valid = rdValid;
    assign bus.rd_err   = rdErr;
    assign bus.rd_data  = rdData;

endmodule

// File: tb/tb_sram_1w_nr_sync.sv
// Bench for sram_1w_nr_sync: two instances (RD_LAT=1/read-first, RD_LAT=3/write-first)
// driven in lockstep against a cycle model and per-port expectation queues.
module tb_sram_1w_nr_sync;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       err;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clrStart = 1'b0;
    logic        wrEn = 1'b0;
    logic [12:0] wrAddr = '0;
    logic [7:0]  wrData = '0;
    logic [1:0]  rdEn = '0;
    logic [25:0] rdAddr = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] model [1024];
    logic       mClear = 1'b0;
    int         mCnt = 0;
    expT        sbQ [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_1w_nr_sync_if #(.DATA_W(8), .ADDR_W(13), .NUM_RD(2)) busA ();
    sram_1w_nr_sync_if #(.DATA_W(8), .ADDR_W(13), .NUM_RD(2)) busB ();

    assign busA.clr_start = clrStart;
    assign busA.wr_en     = wrEn;
    assign busA.wr_addr   = wrAddr;
    assign busA.wr_data   = wrData;
    assign busA.rd_en     = rdEn;
    assign busA.rd_addr   = rdAddr;
    assign busB.clr_start = clrStart;
    assign busB.wr_en     = wrEn;
    assign busB.wr_addr   = wrAddr;
    assign busB.wr_data   = wrData;
    assign busB.rd_en     = rdEn;
    assign busB.rd_addr   = rdAddr;

    sram_1w_nr_sync #(.DATA_W(8), .DEPTH(1024), .ADDR_W(13), .NUM_RD(2), .RD_LAT(1), .WRITE_FIRST(0))
        dutA (.clock(clk), .reset(rst), .bus(busA.slave));
    sram_1w_nr_sync #(.DATA_W(8), .DEPTH(1024), .ADDR_W(13), .NUM_RD(2), .RD_LAT(3), .WRITE_FIRST(1))
        dutB (.clock(clk), .reset(rst), .bus(busB.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, applying the driven inputs to the reference model first
    task automatic cycle();
        logic [12:0] a;
        logic [7:0]  od;
        if (rst) begin
            mClear = 1'b0;
            mCnt   = 0;
        end else if (!mClear) begin
            for (int p = 0; p < 2; p++) begin
                if (rdEn[p]) begin
                    a = rdAddr[p*13 +: 13];
                    if (a < 13'd1024) begin
                        od = model[a[9:0]];
                        sbQ[p].push_back('{cyc + 1, od, 1'b0});
                        sbQ[2+p].push_back('{cyc + 3, (wrEn && wrAddr == a) ? wrData : od, 1'b0});
                    end else begin
                        sbQ[p].push_back('{cyc + 1, 8'h00, 1'b1});
                        sbQ[2+p].push_back('{cyc + 3, 8'h00, 1'b1});
                    end
                end
            end
            if (wrEn && wrAddr < 13'd1024) model[wrAddr[9:0]] = wrData;
            if (clrStart) begin
                mClear = 1'b1;
                mCnt   = 0;
            end
        end else begin
            model[mCnt] = 8'h00;
            if (mCnt == 1023) mClear = 1'b0;
            else mCnt++;
        end
        @(posedge clk);
        #1;
        chk("busyA", 32'(busA.busy), 32'(mClear));
        chk("busyB", 32'(busB.busy), 32'(mClear));
    endtask

    task automatic idleIn();
        clrStart = 1'b0;
        wrEn     = 1'b0;
        rdEn     = '0;
    endtask

    // Read-data monitor: every valid must match the oldest expectation, on its cycle
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic       vv;
            logic       ee;
            logic [7:0] dd;
            expT        e;
            int         p;
            p  = i % 2;
            vv = (i < 2) ? busA.rd_valid[p] : busB.rd_valid[p];
            ee = (i < 2) ? busA.rd_err[p] : busB.rd_err[p];
            dd = (i < 2) ? busA.rd_data[p*8 +: 8] : busB.rd_data[p*8 +: 8];
            if (vv === 1'b1) begin
                if (sbQ[i].size() == 0) begin
                    chk($sformatf("unexpected_valid[%0d]", i), 32'(1), 32'(0));
                end else begin
                    e = sbQ[i].pop_front();
                    chk($sformatf("latency[%0d]", i), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("rd_data[%0d]", i), 32'(dd), 32'(e.data));
                    chk($sformatf("rd_err[%0d]", i), 32'(ee), 32'(e.err));
                end
            end else if (sbQ[i].size() > 0 && sbQ[i][0].cyc <= cyc) begin
                e = sbQ[i].pop_front();
                chk($sformatf("missing_valid[%0d]", i), 32'(vv), 32'(1));
            end
        end
    end

    initial begin
        #1000000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busyCnt;
        int guard;

        repeat (3) cycle();
        rst = 1'b0;
        chk("rst_busyA", 32'(busA.busy), 32'(0));
        chk("rst_validA", 32'(busA.rd_valid), 32'(0));
        chk("rst_errA", 32'(busA.rd_err), 32'(0));
        chk("rst_dataA", 32'(busA.rd_data), 32'(0));
        chk("rst_validB", 32'(busB.rd_valid), 32'(0));
        chk("rst_dataB", 32'(busB.rd_data), 32'(0));

        // T1: write then read one word, then data holds while idle
        wrEn = 1'b1; wrAddr = 13'd3; wrData = 8'hA5;
        cycle();
        idleIn(); rdEn = 2'b01; rdAddr = {13'd0, 13'd3};
        cycle();
        idleIn();
        repeat (5) cycle();
        chk("hold_validA", 32'(busA.rd_valid), 32'(0));
        chk("hold_dataA", 32'(busA.rd_data[7:0]), 32'(8'hA5));
        chk("hold_dataB", 32'(busB.rd_data[7:0]), 32'(8'hA5));

        // T2: back-to-back reads on both ports
        for (int i = 0; i < 8; i++) begin
            wrEn = 1'b1; wrAddr = 13'(i); wrData = 8'(8'h10 + i);
            cycle();
        end
        idleIn();
        for (int i = 0; i < 5; i++) begin
            rdEn = 2'b11; rdAddr = {13'(4 - i), 13'(i)};
            cycle();
        end
        idleIn();
        repeat (4) cycle();

        // T3: same-edge read/write collision on both ports
        wrEn = 1'b1; wrAddr = 13'd7; wrData = 8'h11;
        cycle();
        wrData = 8'h22; rdEn = 2'b11; rdAddr = {13'd7, 13'd7};
        cycle();
        idleIn(); rdEn = 2'b01; rdAddr = {13'd0, 13'd7};
        cycle();
        idleIn();
        repeat (4) cycle();

        // T4: out-of-range read and dropped write (1030 must not alias word 6)
        wrEn = 1'b1; wrAddr = 13'd6; wrData = 8'h66;
        cycle();
        wrAddr = 13'd1030; wrData = 8'hFF; rdEn = 2'b11; rdAddr = {13'd8191, 13'd1024};
        cycle();
        idleIn(); rdEn = 2'b11; rdAddr = {13'd6, 13'd1023};
        cycle();
        idleIn();
        repeat (4) cycle();

        // T5: fill, clear with traffic ignored, then every word reads zero
        for (int i = 0; i < 1024; i++) begin
            wrEn = 1'b1; wrAddr = 13'(i); wrData = 8'(i) ^ 8'h5A;
            cycle();
        end
        idleIn(); clrStart = 1'b1; rdEn = 2'b01; rdAddr = {13'd0, 13'd9};
        cycle();
        busyCnt = 0;
        guard = 0;
        while (mClear && guard < 2000) begin
            if (busA.busy === 1'b1) busyCnt++;
            clrStart = (guard < 10);
            wrEn = 1'b1; wrAddr = 13'd0; wrData = 8'hEE;
            rdEn = 2'b11; rdAddr = {13'd5, 13'd2};
            cycle();
            guard++;
        end
        idleIn();
        chk("busy_cycles", 32'(busyCnt), 32'(1024));
        for (int i = 0; i < 512; i++) begin
            rdEn = 2'b11; rdAddr = {13'(i + 512), 13'(i)};
            cycle();
        end
        idleIn();
        repeat (4) cycle();

        // T6: reset aborts the clear at word 500
        for (int i = 0; i < 1024; i++) begin
            wrEn = 1'b1; wrAddr = 13'(i); wrData = 8'(i) ^ 8'hC3;
            cycle();
        end
        idleIn(); clrStart = 1'b1;
        cycle();
        idleIn();
        repeat (500) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            rdEn = 2'b11; rdAddr = {13'(i + 512), 13'(i)};
            cycle();
        end
        idleIn();
        repeat (6) cycle();

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drained[%0d]", i), 32'(sbQ[i].size()), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
